// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo constants: opcodes, classes, tag ranges, issue states
package tomasulo_pkg;

    localparam int TAG_W    = 3;
    localparam int MAX_TAGS = 7;

    localparam int N_ADD_DEF = 3;
    localparam int N_MUL_DEF = 2;
    localparam int N_LD_DEF  = 2;

    // Tag 0 means "value ready in the register file"; slot tags start at 1.
    localparam int ADD_TAG_BASE = 1;
    localparam int MUL_TAG_BASE = ADD_TAG_BASE + N_ADD_DEF;
    localparam int LD_TAG_BASE  = MUL_TAG_BASE + N_MUL_DEF;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_LD  = 4'd4;
    localparam logic [3:0] OP_ST  = 4'd5;
    localparam logic [3:0] OP_NOP = 4'd15;

    typedef enum logic [1:0] {CL_ADD, CL_MUL, CL_LD, CL_NONE} class_t;

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_STALL} state_t;

    function automatic class_t op_class(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB: return CL_ADD;
            OP_MUL, OP_DIV: return CL_MUL;
            OP_LD, OP_ST:   return CL_LD;
            default:        return CL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alocador_rs.sv
// rtl/alocador_rs.sv - lowest-free priority encoder over one station class's busy bits
module alocador_rs
    import tomasulo_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [N-1:0]     busy,
    output logic             found,
    output logic [TAG_W-1:0] idx
);

    // Scan downward so the lowest free slot is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                idx   = TAG_W'(i);
            end
        end
    end

endmodule

// File: rtl/unidade_de_emissao.sv
// rtl/unidade_de_emissao.sv - in-order issue unit: fetch, decode, slot allocation, renaming, CDB release
module unidade_de_emissao
    import tomasulo_pkg::*;
#(
    parameter int N_ADD = N_ADD_DEF,
    parameter int N_MUL = N_MUL_DEF,
    parameter int N_LD  = N_LD_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Empty,
    input  logic [15:0]         Instrucao,
    output logic                ReadEnable,
    input  logic                CDB_Valid,
    input  logic [TAG_W-1:0]    CDB_Tag,
    output logic                Issue_Valid,
    output logic [3:0]          Issue_Op,
    output logic [TAG_W-1:0]    Issue_Tag,
    output logic [TAG_W-1:0]    Issue_Qj,
    output logic [TAG_W-1:0]    Issue_Qk,
    output logic [3:0]          Issue_Rj,
    output logic [3:0]          Issue_Rk,
    output logic                Erro,
    output logic [MAX_TAGS-1:0] Busy_Vec
);

    localparam int N_TOT    = N_ADD + N_MUL + N_LD;
    localparam int ADD_BASE = ADD_TAG_BASE;
    localparam int MUL_BASE = ADD_BASE + N_ADD;
    localparam int LD_BASE  = MUL_BASE + N_MUL;

    state_t                state_q, state_d;
    logic [15:0]           instr_q, instr_d;
    logic [MAX_TAGS-1:0]   busy_q, busy_d;
    logic [TAG_W-1:0]      rst_q [16];
    logic [TAG_W-1:0]      rst_d [16];
    logic                  issue_valid_q, issue_valid_d;
    logic                  erro_q, erro_d;
    logic [3:0]            issue_op_q, issue_op_d;
    logic [TAG_W-1:0]      issue_tag_q, issue_tag_d;
    logic [TAG_W-1:0]      issue_qj_q, issue_qj_d;
    logic [TAG_W-1:0]      issue_qk_q, issue_qk_d;
    logic [3:0]            issue_rj_q, issue_rj_d;
    logic [3:0]            issue_rk_q, issue_rk_d;

    logic                  found_add, found_mul, found_ld;
    logic [TAG_W-1:0]      idx_add, idx_mul, idx_ld;

    alocador_rs #(.N(N_ADD)) u_aloc_add (
        .busy  (busy_q[N_ADD-1:0]),
        .found (found_add),
        .idx   (idx_add)
    );

    alocador_rs #(.N(N_MUL)) u_aloc_mul (
        .busy  (busy_q[N_ADD+N_MUL-1:N_ADD]),
        .found (found_mul),
        .idx   (idx_mul)
    );

    alocador_rs #(.N(N_LD)) u_aloc_ld (
        .busy  (busy_q[N_TOT-1:N_ADD+N_MUL]),
        .found (found_ld),
        .idx   (idx_ld)
    );

    logic [15:0]      cur;
    logic [3:0]       op, rd, rs, rt, src_k;
    class_t           cls;
    logic             found, do_issue, cdb_hit;
    logic [TAG_W-1:0] alloc_tag, qj_raw, qk_raw;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        busy_d        = busy_q;
        rst_d         = rst_q;
        issue_valid_d = 1'b0;
        erro_d        = 1'b0;
        issue_op_d    = issue_op_q;
        issue_tag_d   = issue_tag_q;
        issue_qj_d    = issue_qj_q;
        issue_qk_d    = issue_qk_q;
        issue_rj_d    = issue_rj_q;
        issue_rk_d    = issue_rk_q;
        ReadEnable    = 1'b0;
        do_issue      = 1'b0;
        found         = 1'b0;
        alloc_tag     = '0;

        // A stalled instruction lives in instr_q; in DECODE the queue output is already valid.
        cur   = (state_q == S_STALL) ? instr_q : Instrucao;
        op    = cur[15:12];
        rd    = cur[11:8];
        rs    = cur[7:4];
        rt    = cur[3:0];
        cls   = op_class(op);
        src_k = (op == OP_ST) ? rd : rt;

        case (cls)
            CL_ADD: begin found = found_add; alloc_tag = TAG_W'(ADD_BASE) + idx_add; end
            CL_MUL: begin found = found_mul; alloc_tag = TAG_W'(MUL_BASE) + idx_mul; end
            CL_LD:  begin found = found_ld;  alloc_tag = TAG_W'(LD_BASE) + idx_ld;   end
            default: ;
        endcase

        cdb_hit = CDB_Valid && (CDB_Tag != '0) && (CDB_Tag <= TAG_W'(N_TOT));
        qj_raw  = rst_q[rs];
        qk_raw  = rst_q[src_k];

        case (state_q)
            S_FETCH: begin
                if (!Empty && !Reset) begin
                    ReadEnable = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                instr_d = Instrucao;
                if (cls == CL_NONE) begin
                    erro_d  = (op != OP_NOP);
                    state_d = S_FETCH;
                end else if (found) begin
                    do_issue = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (found) begin
                    do_issue = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (cdb_hit) begin
            for (int i = 0; i < MAX_TAGS; i++) begin
                if (CDB_Tag == TAG_W'(i + 1)) busy_d[i] = 1'b0;
            end
            for (int r = 0; r < 16; r++) begin
                if (rst_q[r] == CDB_Tag) rst_d[r] = '0;
            end
        end

        // Sources read the pre-rename table with CDB bypass; the rename is applied last so it wins.
        if (do_issue) begin
            issue_valid_d = 1'b1;
            issue_op_d    = op;
            issue_tag_d   = alloc_tag;
            issue_rj_d    = rs;
            issue_rk_d    = (op == OP_LD) ? 4'd0 : src_k;
            issue_qj_d    = (cdb_hit && qj_raw == CDB_Tag) ? '0 : qj_raw;
            issue_qk_d    = (op == OP_LD || (cdb_hit && qk_raw == CDB_Tag)) ? '0 : qk_raw;
            for (int i = 0; i < MAX_TAGS; i++) begin
                if (alloc_tag == TAG_W'(i + 1)) busy_d[i] = 1'b1;
            end
            if (op != OP_ST) rst_d[rd] = alloc_tag;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_FETCH;
            instr_q       <= '0;
            busy_q        <= '0;
            for (int r = 0; r < 16; r++) rst_q[r] <= '0;
            issue_valid_q <= 1'b0;
            erro_q        <= 1'b0;
            issue_op_q    <= '0;
            issue_tag_q   <= '0;
            issue_qj_q    <= '0;
            issue_qk_q    <= '0;
            issue_rj_q    <= '0;
            issue_rk_q    <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            busy_q        <= busy_d;
            rst_q         <= rst_d;
            issue_valid_q <= issue_valid_d;
            erro_q        <= erro_d;
            issue_op_q    <= issue_op_d;
            issue_tag_q   <= issue_tag_d;
            issue_qj_q    <= issue_qj_d;
            issue_qk_q    <= issue_qk_d;
            issue_rj_q    <= issue_rj_d;
            issue_rk_q    <= issue_rk_d;
        end
    end

    assign Issue_Valid = issue_valid_q;
    assign Erro        = erro_q;
    assign Issue_Op    = issue_op_q;
    assign Issue_Tag   = issue_tag_q;
    assign Issue_Qj    = issue_qj_q;
    assign Issue_Qk    = issue_qk_q;
    assign Issue_Rj    = issue_rj_q;
    assign Issue_Rk    = issue_rk_q;
    assign Busy_Vec    = busy_q;

endmodule

// File: tb/tb_unidade_de_emissao.sv
// tb/tb_unidade_de_emissao.sv - directed self-checking bench for unidade_de_emissao
module tb_unidade_de_emissao;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Empty;
    logic [15:0] Instrucao;
    logic        ReadEnable;
    logic        CDB_Valid;
    logic [2:0]  CDB_Tag;
    logic        Issue_Valid;
    logic [3:0]  Issue_Op;
    logic [2:0]  Issue_Tag;
    logic [2:0]  Issue_Qj;
    logic [2:0]  Issue_Qk;
    logic [3:0]  Issue_Rj;
    logic [3:0]  Issue_Rk;
    logic        Erro;
    logic [6:0]  Busy_Vec;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] fifo[$];

    unidade_de_emissao dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Empty       (Empty),
        .Instrucao   (Instrucao),
        .ReadEnable  (ReadEnable),
        .CDB_Valid   (CDB_Valid),
        .CDB_Tag     (CDB_Tag),
        .Issue_Valid (Issue_Valid),
        .Issue_Op    (Issue_Op),
        .Issue_Tag   (Issue_Tag),
        .Issue_Qj    (Issue_Qj),
        .Issue_Qk    (Issue_Qk),
        .Issue_Rj    (Issue_Rj),
        .Issue_Rk    (Issue_Rk),
        .Erro        (Erro),
        .Busy_Vec    (Busy_Vec)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] ins);
        fifo.push_back(ins);
        Empty = 1'b0;
    endtask

    // One clock: the queue model pops on an edge that samples ReadEnable high.
    task automatic step();
        logic pop;
        #1;
        pop = ReadEnable;
        @(posedge Clock);
        #1;
        if (pop && fifo.size() > 0) Instrucao = fifo.pop_front();
        Empty = (fifo.size() == 0);
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic [2:0] t, input logic [2:0] qj,
                             input logic [2:0] qk, input logic [6:0] busy);
        chk({tag, ".valid"}, Issue_Valid, 1'b1);
        chk({tag, ".tag"},   Issue_Tag, t);
        chk({tag, ".qj"},    Issue_Qj, qj);
        chk({tag, ".qk"},    Issue_Qk, qk);
        chk({tag, ".busy"},  Busy_Vec, busy);
    endtask

    task automatic do_reset(input string tag);
        #2 Reset = 1'b1;
        #1;
        chk({tag, ".busy0"},  Busy_Vec, 7'h00);
        chk({tag, ".valid0"}, Issue_Valid, 1'b0);
        chk({tag, ".tag0"},   Issue_Tag, 3'd0);
        chk({tag, ".re0"},    ReadEnable, 1'b0);
        fifo.delete();
        Empty     = 1'b1;
        Instrucao = 16'h0000;
        CDB_Valid = 1'b0;
        CDB_Tag   = 3'd0;
        #1 Reset = 1'b0;
        @(posedge Clock);
        #2;
    endtask

    initial begin
        Reset     = 1'b1;
        Empty     = 1'b1;
        Instrucao = 16'h0000;
        CDB_Valid = 1'b0;
        CDB_Tag   = 3'd0;
        #3;
        chk("rst.re",    ReadEnable, 1'b0);
        chk("rst.valid", Issue_Valid, 1'b0);
        chk("rst.erro",  Erro, 1'b0);
        chk("rst.busy",  Busy_Vec, 7'h00);
        chk("rst.op",    Issue_Op, 4'd0);
        chk("rst.qj",    Issue_Qj, 3'd0);
        #4 Reset = 1'b0;
        @(posedge Clock);
        #2;

        // ADD r1,r2,r3 ; MUL r4,r1,r1 ; ST r4 <- r1 (reveals RST[1], RST[4])
        push(16'h0123); push(16'h2411); push(16'h5410);
        #1 chk("s1.re", ReadEnable, 1'b1);
        step(); step();
        chk_issue("s1.add", 3'd1, 3'd0, 3'd0, 7'h01);
        chk("s1.add.op", Issue_Op, 4'd0);
        step();
        chk("s1.gap", Issue_Valid, 1'b0);
        step();
        chk_issue("s1.mul", 3'd4, 3'd1, 3'd1, 7'h09);
        step(); step();
        chk_issue("s1.st", 3'd6, 3'd1, 3'd4, 7'h29);
        chk("s1.st.rj", Issue_Rj, 4'd1);
        chk("s1.st.rk", Issue_Rk, 4'd4);
        chk("s1.empty.re", ReadEnable, 1'b0);

        // Four ADDs with three slots, then a NOP waiting in the queue
        do_reset("s2");
        push(16'h0100); push(16'h0200); push(16'h0300); push(16'h0812); push(16'hF000);
        step(); step(); chk_issue("s2.a1", 3'd1, 3'd0, 3'd0, 7'h01);
        step(); step(); chk_issue("s2.a2", 3'd2, 3'd0, 3'd0, 7'h03);
        step(); step(); chk_issue("s2.a3", 3'd3, 3'd0, 3'd0, 7'h07);
        step();
        chk("s2.stall.valid", Issue_Valid, 1'b0);
        chk("s2.stall.re", ReadEnable, 1'b0);
        step();
        chk("s2.stall2.valid", Issue_Valid, 1'b0);
        chk("s2.stall2.re", ReadEnable, 1'b0);
        CDB_Valid = 1'b1; CDB_Tag = 3'd2;
        step();
        CDB_Valid = 1'b0; CDB_Tag = 3'd0;
        chk("s2.t1.valid", Issue_Valid, 1'b0);
        chk("s2.t1.busy", Busy_Vec, 7'h05);
        step();
        chk_issue("s2.a4", 3'd2, 3'd1, 3'd0, 7'h07);
        step(); step();
        chk("s2.nop.valid", Issue_Valid, 1'b0);
        chk("s2.nop.erro", Erro, 1'b0);

        // CDB/issue collision, rd==source, and dest write overriding a clear
        do_reset("s3");
        push(16'h0500); push(16'h1650); push(16'h0956);
        push(16'h0999); push(16'h2A90); push(16'h2900); push(16'h5990);
        step(); step(); chk_issue("s3.add5", 3'd1, 3'd0, 3'd0, 7'h01);
        step();
        CDB_Valid = 1'b1; CDB_Tag = 3'd1;
        step();
        CDB_Valid = 1'b0; CDB_Tag = 3'd0;
        chk_issue("s3.sub", 3'd2, 3'd0, 3'd0, 7'h02);
        chk("s3.sub.rj", Issue_Rj, 4'd5);
        step(); step(); chk_issue("s3.r9", 3'd1, 3'd0, 3'd2, 7'h03);
        step(); step(); chk_issue("s3.self", 3'd3, 3'd1, 3'd1, 7'h07);
        step(); step(); chk_issue("s3.mul", 3'd4, 3'd3, 3'd0, 7'h0F);
        step();
        CDB_Valid = 1'b1; CDB_Tag = 3'd3;
        step();
        CDB_Valid = 1'b0; CDB_Tag = 3'd0;
        chk_issue("s3.ovr", 3'd5, 3'd0, 3'd0, 7'h1B);
        step(); step(); chk_issue("s3.st", 3'd6, 3'd5, 3'd5, 7'h3B);

        // NOP, illegal opcode 9, ST r7,r2 with RST[7] held by an ADD
        do_reset("s4");
        push(16'h0700); push(16'hF000); push(16'h9000); push(16'h5720); push(16'h2170);
        step(); step(); chk_issue("s4.add7", 3'd1, 3'd0, 3'd0, 7'h01);
        step(); step();
        chk("s4.nop.valid", Issue_Valid, 1'b0);
        chk("s4.nop.erro", Erro, 1'b0);
        step(); step();
        chk("s4.ill.erro", Erro, 1'b1);
        chk("s4.ill.valid", Issue_Valid, 1'b0);
        step(); step();
        chk_issue("s4.st", 3'd6, 3'd0, 3'd1, 7'h21);
        chk("s4.st.erro", Erro, 1'b0);
        chk("s4.st.op", Issue_Op, 4'd5);
        step(); step();
        chk_issue("s4.mul", 3'd4, 3'd1, 3'd0, 7'h29);

        // Reset while stalled
        do_reset("s5a");
        push(16'h0100); push(16'h0200); push(16'h0300); push(16'h0312);
        for (int i = 0; i < 8; i++) step();
        chk("s5.pre.busy", Busy_Vec, 7'h07);
        do_reset("s5b");
        push(16'h0412);
        step(); step();
        chk_issue("s5.post", 3'd1, 3'd0, 3'd0, 7'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_de_emissao.md
# unidade_de_emissao

In-order issue controller for the Tomasulo datapath. It sits between `fila_de_instrucoes` and the reservation stations. It pulls one instruction at a time from the queue, decodes it, and allocates a free reservation-station slot of the required class. It renames the destination register in the register status table and emits source tags, then releases slots and clears tags on Common Data Bus broadcasts.

## Interface
- N_ADD, 3, ADD/SUB station slots; tags 1..N_ADD
- N_MUL, 2, MUL/DIV station slots; tags N_ADD+1..N_ADD+N_MUL
- N_LD, 2, LD/ST buffer slots; next tags up; N_ADD+N_MUL+N_LD ≤ 7 (3-bit tag, 0 = "ready/none")
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- Empty  in  1  queue empty flag
- Instrucao  in  16  queue's `Instrucao_Despachada`; op[15:12], rd[11:8], rs[7:4], rt[3:0]
- ReadEnable  out  1  one-cycle pop request to the queue
- CDB_Valid  in  1  broadcast valid
- CDB_Tag  in  3  tag of the finishing slot
- Issue_Valid  out  1  one-cycle pulse: issue bundle valid
- Issue_Op  out  4  opcode issued
- Issue_Tag  out  3  allocated slot tag
- Issue_Qj / Issue_Qk  out  3 each  producer tag of the first/second source; 0 = value in the register file
- Issue_Rj / Issue_Rk  out  4 each  source register indices
- Erro  out  1  one-cycle pulse on an illegal opcode
- Busy_Vec  out  7  slot occupancy; bit i-1 = tag i

## Operation
- Opcodes:
  - 0 ADD, 1 SUB → ADD class
  - 2 MUL, 3 DIV → MUL class
  - 4 LD → LD class; dest rd, source rs
  - 5 ST → LD class; sources rs, rd; no rename
  - 15 NOP → consumed, nothing issued
  - all others illegal → consumed, Erro pulses
- ALU ops (0–3): sources rs, rt; dest rd.
- FSM states: FETCH, DECODE, STALL.
  - FETCH: if Empty=0, assert ReadEnable and go to DECODE; otherwise stay.
  - DECODE: the instruction is held in an internal register.
    - Free slot of the class: issue, go to FETCH.
    - No free slot: go to STALL.
    - NOP or illegal: go to FETCH.
  - STALL: re-check the held instruction every cycle; issue as soon as a slot of its class is free, then go to FETCH. ReadEnable is never asserted in STALL.
- Allocation picks the lowest-numbered free slot in the class and sets its busy bit.
- Register status table: 16 × 3-bit. On issue with a dest, RST[rd] ← Issue_Tag; Qj/Qk are read from the RST.
- CDB_Valid clears the busy bit of CDB_Tag and zeroes every RST entry equal to CDB_Tag. CDB_Tag=0 or an unused tag is ignored.
- Simultaneous events:
  - CDB and issue in the same cycle:
    - Source lookup bypasses; an RST entry matching CDB_Tag yields Q=0.
    - The dest write overrides the clear when the registers coincide.
  - A slot freed by the CDB in cycle t is allocatable from cycle t+1 only.
  - An instruction whose rd equals a source reads the old tag for the source, then renames.
- Reset mid-operation: FSM → FETCH; all busy bits, RST entries and outputs cleared; the held instruction is dropped.

## Timing
- Reset values: ReadEnable=0, Issue_Valid=0, Erro=0, Issue_* =0, Busy_Vec=0, state FETCH.
- All outputs are registered except ReadEnable, which is a Moore output of FETCH gated by Empty.
- Throughput: one instruction per 2 cycles at best (FETCH, DECODE).
- Issue latency from ReadEnable: the Issue_Valid pulse lands in the cycle after DECODE when the class has a free slot.
- Erro timing matches Issue_Valid; it fires on illegal opcodes instead of an issue.
- The queue updates Instrucao on the edge that samples ReadEnable, so DECODE samples Instrucao directly.
- Empty is trusted as-is. A pop on a stale Empty=0 returns the previous instruction. The queue guarantees this does not occur.

## Structure
- `tomasulo_pkg` holds:
  - opcode constants
  - class encoding (CL_ADD, CL_MUL, CL_LD)
  - tag width
  - tag-range base constants shared with the reservation stations and CDB arbiter
  - state encoding
- One sub-module, `alocador_rs`: lowest-free priority encoder over a busy-bit slice, returning found/index. It is instantiated once per class.

## Test plan
- Issue and rename:
  - Stimulus: queue holds ADD r1,r2,r3 then MUL r4,r1,r1, no CDB.
  - Response: ADD issues Tag=1, Qj=Qk=0. MUL issues Tag=4, Qj=Qk=1. RST[1]=1, RST[4]=4.
- Stall:
  - Stimulus: 4 consecutive ADDs with N_ADD=3.
  - Response: first three get tags 1,2,3. The fourth holds in STALL with ReadEnable=0.
  - Follow-up: CDB_Tag=2 in cycle t → fourth issues Tag=2, Issue_Valid pulsing in cycle t+2.
- CDB/issue collision:
  - Stimulus: ADD r5 pending with tag 1; SUB r6,r5,r0 decoded while CDB_Tag=1 arrives.
  - Response: Qj=0, and RST[5] is cleared.
- NOP, illegal opcode and ST:
  - Stimulus: opcode 15, opcode 9, then ST r7,r2.
  - Response: no issue for the NOP; one Erro pulse for opcode 9. ST gets tag 6 and leaves RST[7] unchanged.
- Reset mid-operation:
  - Stimulus: assert Reset asynchronously while in STALL with slots busy.
  - Response: immediately Busy_Vec=0 and RST all zero. State is FETCH, and the first post-reset instruction gets tag 1.
